// File: rtl/eventsystem_pkg.sv
// Shared sizing helpers for the event ring controller.
package eventsystem_pkg;

   // Ceiling log2 usable in constant expressions; clog2(0) and clog2(1) are 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Slot index width; at least one bit so a single-slot ring still has a port.
   function automatic int unsigned slot_w(input int unsigned depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   // Occupancy width: must represent 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
   endfunction

endpackage

// File: rtl/eventsystem_ring_if.sv
// Stage handshake and slot-index bundle between the ring controller and its stages.
interface eventsystem_ring_if #(
   parameter int unsigned STAGES = 6,
   parameter int unsigned DEPTH  = 2
);
   import eventsystem_pkg::*;

   localparam int unsigned SLOT_W = slot_w(DEPTH);
   localparam int unsigned CNT_W  = cnt_w(DEPTH);

   logic [STAGES-1:0]              stage_done;
   logic [STAGES-1:0]              stage_ready;
   logic [STAGES-1:0]              stage_busy;
   logic [(STAGES-1)*SLOT_W-1:0]   wr_slot;
   logic [(STAGES-1)*SLOT_W-1:0]   rd_slot;
   logic [(STAGES-1)*CNT_W-1:0]    occupancy;
   logic                           protocol_err;

   // Stage side: reports done, receives starts and slot indices.
   modport master (
      output stage_done,
      input  stage_ready, stage_busy, wr_slot, rd_slot, occupancy, protocol_err
   );

   // Controller side.
   modport slave (
      input  stage_done,
      output stage_ready, stage_busy, wr_slot, rd_slot, occupancy, protocol_err
   );

endinterface

// File: rtl/eventsystem_ring_boundary.sv
// One inter-stage ring: write/read pointers and committed-slot count.
module eventsystem_ring_boundary
   import eventsystem_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned SLOT_W = 1,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [SLOT_W-1:0] wr_ptr,
   output logic [SLOT_W-1:0] rd_ptr,
   output logic [CNT_W-1:0]  count,
   output logic              full_c,
   output logic              empty_c
);

   logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
   function automatic logic [SLOT_W-1:0] next_ptr(input logic [SLOT_W-1:0] p);
      return (p == SLOT_W'(DEPTH - 1)) ? '0 : p + SLOT_W'(1);
   endfunction

   // Next-state: producer commit advances wr_ptr, consumer release advances rd_ptr.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (inc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (dec) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({inc, dec})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr  = wr_ptr_q;
   assign rd_ptr  = rd_ptr_q;
   assign count   = count_q;
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);

endmodule

// File: rtl/eventsystem_ring.sv
// Pipeline event controller: sequences STAGES stages through DEPTH-slot rings.
module eventsystem_ring
   import eventsystem_pkg::*;
#(
   parameter int unsigned STAGES      = 6,
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned READY_DELAY = 1
) (
   input  logic               clk,
   input  logic               rst,
   eventsystem_ring_if.slave  bus
);

   localparam int unsigned SLOT_W = slot_w(DEPTH);
   localparam int unsigned CNT_W  = cnt_w(DEPTH);
   localparam int unsigned NB     = STAGES - 1;

   logic [STAGES-1:0]                busy_q, busy_d;
   logic [STAGES-1:0][READY_DELAY:0] chain_q, chain_d;
   logic                             err_q, err_d;

   logic [STAGES-1:0] accept_c, start_c, has_in_c, has_room_c, ready_c;
   logic [NB-1:0]     full_c, empty_c;

   logic [NB-1:0][SLOT_W-1:0] wr_ptr_w, rd_ptr_w;
   logic [NB-1:0][CNT_W-1:0]  count_w;

   // A done only counts while the stage is actually running.
   assign accept_c = bus.stage_done & busy_q;

   // First stage always has input; last stage always has room.
   assign has_in_c[0]          = 1'b1;
   assign has_room_c[STAGES-1] = 1'b1;

   // Boundary i: producer stage i, consumer stage i+1.
   for (genvar i = 0; i < NB; i++) begin : g_bnd
      assign has_room_c[i]  = ~full_c[i];
      assign has_in_c[i+1]  = ~empty_c[i];

      eventsystem_ring_boundary #(
         .DEPTH  (DEPTH),
         .SLOT_W (SLOT_W),
         .CNT_W  (CNT_W)
      ) u_bnd (
         .clk     (clk),
         .rst     (rst),
         .inc     (accept_c[i]),
         .dec     (accept_c[i+1]),
         .wr_ptr  (wr_ptr_w[i]),
         .rd_ptr  (rd_ptr_w[i]),
         .count   (count_w[i]),
         .full_c  (full_c[i]),
         .empty_c (empty_c[i])
      );
   end

   // Start decisions from registered state, busy update, ready delay chains, error flag.
   always_comb begin
      start_c = '0;
      ready_c = '0;
      chain_d = chain_q;
      for (int s = 0; s < int'(STAGES); s++) begin
         start_c[s] = ~busy_q[s] & has_in_c[s] & has_room_c[s];
         chain_d[s] = {chain_q[s][READY_DELAY-1:0], start_c[s]};
         ready_c[s] = chain_q[s][READY_DELAY];
      end
      // Accept and start are mutually exclusive per stage, so no same-edge restart.
      busy_d = (busy_q & ~accept_c) | start_c;
      err_d  = err_q | (|(bus.stage_done & ~busy_q));
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         chain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         chain_q <= chain_d;
         err_q   <= err_d;
      end
   end

   assign bus.stage_ready  = ready_c;
   assign bus.stage_busy   = busy_q;
   assign bus.protocol_err = err_q;
   assign bus.wr_slot      = wr_ptr_w;
   assign bus.rd_slot      = rd_ptr_w;
   assign bus.occupancy    = count_w;

endmodule
